ula_seq: RTL and testbench

- Parametrised, clocked successor to the 32-bit combinational ALU in the MIPS datapath.
- Adds registered results and a start/busy/done handshake.
- Adds true signed/unsigned semantics, signed overflow detection, and iterative multiply/divide into HI/LO registers.
- Sits in the EX stage; the control unit stalls the pipeline while busy is high.

---
 rtl/ula_seq.sv | 228 ++++++++++++++++++++++
 tb/tb_ula_seq.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_seq.sv
// Clocked MIPS EX-stage ALU: single-cycle logic/arith ops plus iterative
// multiply/divide into HI/LO behind a start/busy/done handshake.
module ula_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic             z,
  output logic             ovf,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             brk
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_ADDU  = 4'b0100;
  localparam logic [3:0] OP_SUBU  = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULT  = 4'b1000;
  localparam logic [3:0] OP_MULTU = 4'b1001;
  localparam logic [3:0] OP_SLTU  = 4'b1010;
  localparam logic [3:0] OP_DIV   = 4'b1011;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;
  localparam logic [3:0] OP_MFHL  = 4'b1110;
  localparam logic [3:0] OP_BRK   = 4'b1111;

  logic [1:0]         state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   acc_hi, acc_lo, m;
  logic               is_div_r, neg_lo_r, neg_hi_r, dz_r;

  logic               is_mul_op, is_div_op, sgn_op, a_neg, b_neg;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH-1:0]   sum, diff, alu_s;
  logic               alu_ovf;
  logic [WIDTH:0]     mul_sum, div_try;
  logic [WIDTH-1:0]   step_hi, step_lo, fin_hi, fin_lo;
  logic [2*WIDTH-1:0] prod, prod_neg;

  assign is_mul_op = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div_op = (op == OP_DIV) || (op == OP_DIVU);
  assign sgn_op    = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg     = sgn_op && a[WIDTH-1];
  assign b_neg     = sgn_op && b[WIDTH-1];
  assign abs_a     = a_neg ? -a : a;
  assign abs_b     = b_neg ? -b : b;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; a zero divisor bypasses the iteration phase
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start && is_mul_op)      state_nxt = RUN;
        else if (start && is_div_op) state_nxt = (b == '0) ? FIN : RUN;
      end
      RUN:     if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Single-cycle operations
  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    alu_s   = '0;
    alu_ovf = 1'b0;
    case (op)
      OP_AND:  alu_s = a & b;
      OP_OR:   alu_s = a | b;
      OP_ADD: begin
        alu_s   = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_XOR:  alu_s = a ^ b;
      OP_ADDU: alu_s = sum;
      OP_SUBU: alu_s = diff;
      OP_SUB: begin
        alu_s   = diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  alu_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_s = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_NOR:  alu_s = ~(a | b);
      OP_MFHL: alu_s = b[0] ? hi : lo;
      default: alu_s = '0;
    endcase
  end

  // One shift-add or restoring-divide iteration on the shared accumulator
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m} : '0);
  assign div_try = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, m};

  always_comb begin
    step_hi = {mul_sum[WIDTH:1]};
    step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    if (is_div_r) begin
      if (!div_try[WIDTH]) begin
        step_hi = div_try[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
        step_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Sign fix-up of the magnitude result
  assign prod     = {acc_hi, acc_lo};
  assign prod_neg = -prod;

  always_comb begin
    fin_hi = hi;
    fin_lo = lo;
    if (!dz_r) begin
      if (is_div_r) begin
        fin_lo = neg_lo_r ? -acc_lo : acc_lo;
        fin_hi = neg_hi_r ? -acc_hi : acc_hi;
      end else begin
        fin_hi = neg_lo_r ? prod_neg[2*WIDTH-1:WIDTH] : acc_hi;
        fin_lo = neg_lo_r ? prod_neg[WIDTH-1:0]       : acc_lo;
      end
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s        <= '0;
      z        <= 1'b1;
      ovf      <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      brk      <= 1'b0;
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      m        <= '0;
      is_div_r <= 1'b0;
      neg_lo_r <= 1'b0;
      neg_hi_r <= 1'b0;
      dz_r     <= 1'b0;
    end else begin
      done     <= 1'b0;
      brk      <= 1'b0;
      div_zero <= 1'b0;
      busy     <= (state_nxt != IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            if (is_mul_op) begin
              acc_hi   <= '0;
              acc_lo   <= abs_b;
              m        <= abs_a;
              is_div_r <= 1'b0;
              neg_lo_r <= a_neg ^ b_neg;
              neg_hi_r <= 1'b0;
              dz_r     <= 1'b0;
              cnt      <= '0;
            end else if (is_div_op) begin
              acc_hi   <= '0;
              acc_lo   <= abs_a;
              m        <= abs_b;
              is_div_r <= 1'b1;
              neg_lo_r <= a_neg ^ b_neg;
              neg_hi_r <= a_neg;
              dz_r     <= (b == '0);
              cnt      <= '0;
            end else if (op == OP_BRK) begin
              ovf  <= 1'b0;
              brk  <= 1'b1;
              done <= 1'b1;
            end else begin
              s    <= alu_s;
              z    <= (alu_s == '0);
              ovf  <= alu_ovf;
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + CNT_W'(1);
        end
        FIN: begin
          hi       <= fin_hi;
          lo       <= fin_lo;
          s        <= fin_lo;
          z        <= (fin_lo == '0);
          ovf      <= 1'b0;
          done     <= 1'b1;
          div_zero <= dz_r;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_seq.sv
// Self-checking bench for ula_seq: directed table, handshake/reset corner
// sequences, randomized ops against a 64-bit arithmetic model, and WIDTH=8.
module tb_ula_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, st, st8;
  logic [3:0]  op, op8;
  logic [31:0] a, b;
  logic [7:0]  a8, b8;
  logic [31:0] s, hi, lo;
  logic        z, ovf, busy, done, dz, brk;
  logic [7:0]  s8, hi8, lo8;
  logic        z8, ovf8, busy8, done8, dz8, brk8;

  ula_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(st), .op(op), .a(a), .b(b),
    .s(s), .z(z), .ovf(ovf), .hi(hi), .lo(lo), .busy(busy), .done(done),
    .div_zero(dz), .brk(brk));

  ula_seq #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .op(op8), .a(a8), .b(b8),
    .s(s8), .z(z8), .ovf(ovf8), .hi(hi8), .lo(lo8), .busy(busy8), .done(done8),
    .div_zero(dz8), .brk(brk8));

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, s, hi, lo;
    logic        ovf, dz, brk;
    int          lat;
  } vec_t;

  logic [31:0] m_hi, m_lo, m_s;
  logic        m_z;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit signed/unsigned arithmetic
  function automatic vec_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    vec_t r;
    longint sx, sy, p;
    logic [63:0] up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r.op = o; r.a = x; r.b = y;
    r.hi = m_hi; r.lo = m_lo; r.s = m_s;
    r.ovf = 1'b0; r.dz = 1'b0; r.brk = 1'b0; r.lat = 1;
    case (o)
      4'h0: r.s = x & y;
      4'h1: r.s = x | y;
      4'h2: begin p = sx + sy; r.s = p[31:0]; r.ovf = (p != longint'($signed(r.s))); end
      4'h3: r.s = x ^ y;
      4'h4: r.s = x + y;
      4'h5: r.s = x - y;
      4'h6: begin p = sx - sy; r.s = p[31:0]; r.ovf = (p != longint'($signed(r.s))); end
      4'h7: r.s = (sx < sy) ? 32'd1 : 32'd0;
      4'hA: r.s = (x < y) ? 32'd1 : 32'd0;
      4'hC: r.s = ~(x | y);
      4'h8: begin p = sx * sy; r.hi = p[63:32]; r.lo = p[31:0]; r.s = r.lo; r.lat = 34; end
      4'h9: begin up = 64'(x) * 64'(y); r.hi = up[63:32]; r.lo = up[31:0]; r.s = r.lo; r.lat = 34; end
      4'hB, 4'hD: begin
        if (y == 32'd0) begin
          r.dz = 1'b1; r.s = m_lo; r.lat = 2;
        end else begin
          if (o == 4'hB) begin
            p = sx / sy; r.lo = p[31:0];
            p = sx % sy; r.hi = p[31:0];
          end else begin
            r.lo = x / y; r.hi = x % y;
          end
          r.s = r.lo; r.lat = 34;
        end
      end
      4'hE: r.s = y[0] ? m_hi : m_lo;
      default: begin r.s = m_s; r.brk = 1'b1; end
    endcase
    return r;
  endfunction

  // Issue one op on the 32-bit unit and check every output at done
  task automatic apply(input vec_t v, input string tag);
    int n, nb;
    logic ez;
    ez = v.brk ? m_z : (v.s == 32'd0);
    op = v.op; a = v.a; b = v.b; st = 1'b1;
    n = 0; nb = 0;
    do begin
      @(posedge clk); #1;
      st = 1'b0;
      n++;
      if (!done && busy) nb++;
    end while (!done && n < 100);
    chk({tag, "/latency"}, 64'(n), 64'(v.lat));
    chk({tag, "/busy_cycles"}, 64'(nb), 64'(v.lat - 1));
    chk({tag, "/s"}, 64'(s), 64'(v.s));
    chk({tag, "/z"}, 64'(z), 64'(ez));
    chk({tag, "/ovf"}, 64'(ovf), 64'(v.ovf));
    chk({tag, "/hi"}, 64'(hi), 64'(v.hi));
    chk({tag, "/lo"}, 64'(lo), 64'(v.lo));
    chk({tag, "/div_zero"}, 64'(dz), 64'(v.dz));
    chk({tag, "/brk"}, 64'(brk), 64'(v.brk));
    chk({tag, "/busy_at_done"}, 64'(busy), 64'd0);
    m_hi = v.hi; m_lo = v.lo; m_s = v.s; m_z = ez;
    @(posedge clk); #1;
    chk({tag, "/done_pulse"}, 64'(done), 64'd0);
  endtask

  vec_t tbl[15];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, pulses;
    logic [3:0]  o;
    logic [31:0] x, y;

    tbl[0]  = '{4'h2, 32'd5,         32'd7,         32'd12,        32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1};
    tbl[1]  = '{4'h2, 32'h7FFFFFFF,  32'd1,         32'h80000000,  32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 1};
    tbl[2]  = '{4'h7, 32'hFFFFFFFF,  32'd1,         32'd1,         32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1};
    tbl[3]  = '{4'hA, 32'hFFFFFFFF,  32'd1,         32'd0,         32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1};
    tbl[4]  = '{4'h5, 32'd3,         32'd5,         32'hFFFFFFFE,  32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1};
    tbl[5]  = '{4'h8, 32'hFFFFFFFD,  32'd7,         32'hFFFFFFEB,  32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0, 1'b0, 34};
    tbl[6]  = '{4'h9, 32'hFFFFFFFD,  32'd7,         32'hFFFFFFEB,  32'h6,        32'hFFFFFFEB, 1'b0, 1'b0, 1'b0, 34};
    tbl[7]  = '{4'hB, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b0, 34};
    tbl[8]  = '{4'hD, 32'd7,         32'd0,         32'hFFFFFFFD,  32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b1, 1'b0, 2};
    tbl[9]  = '{4'hE, 32'd0,         32'd1,         32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b0, 1};
    tbl[10] = '{4'hB, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'h0,        32'h80000000, 1'b0, 1'b0, 1'b0, 34};
    tbl[11] = '{4'h6, 32'h80000000,  32'd1,         32'h7FFFFFFF,  32'h0,        32'h80000000, 1'b1, 1'b0, 1'b0, 1};
    tbl[12] = '{4'hF, 32'd0,         32'd0,         32'h7FFFFFFF,  32'h0,        32'h80000000, 1'b0, 1'b0, 1'b1, 1};
    tbl[13] = '{4'hC, 32'd0,         32'd0,         32'hFFFFFFFF,  32'h0,        32'h80000000, 1'b0, 1'b0, 1'b0, 1};
    tbl[14] = '{4'hE, 32'd0,         32'd0,         32'h80000000,  32'h0,        32'h80000000, 1'b0, 1'b0, 1'b0, 1};

    rst_n = 1'b0; st = 1'b0; st8 = 1'b0;
    op = 4'h0; a = '0; b = '0; op8 = 4'h0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset/s", 64'(s), 64'd0);
    chk("reset/z", 64'(z), 64'd1);
    chk("reset/hi", 64'(hi), 64'd0);
    chk("reset/lo", 64'(lo), 64'd0);
    chk("reset/busy", 64'(busy), 64'd0);
    chk("reset/done", 64'(done), 64'd0);
    chk("reset8/s", 64'(s8), 64'd0);
    chk("reset8/z", 64'(z8), 64'd1);
    rst_n = 1'b1;
    m_hi = '0; m_lo = '0; m_s = '0; m_z = 1'b1;

    for (int i = 0; i < 15; i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // Back-to-back: new start accepted in the cycle done is high
    op = 4'h2; a = 32'd1; b = 32'd2; st = 1'b1;
    @(posedge clk); #1;
    chk("b2b/done1", 64'(done), 64'd1);
    chk("b2b/s1", 64'(s), 64'd3);
    op = 4'h1; a = 32'd4; b = 32'd1;
    @(posedge clk); #1;
    st = 1'b0;
    chk("b2b/done2", 64'(done), 64'd1);
    chk("b2b/s2", 64'(s), 64'd5);
    m_s = 32'd5; m_z = 1'b0;
    @(posedge clk); #1;
    chk("b2b/done_low", 64'(done), 64'd0);

    // Start while busy is ignored
    op = 4'h8; a = 32'hFFFFFFFB; b = 32'd6; st = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 5) begin st = 1'b1; op = 4'h2; a = 32'd1; b = 32'd1; end
      else st = 1'b0;
    end while (!done && n < 100);
    chk("ignore/latency", 64'(n), 64'd34);
    chk("ignore/hi", 64'(hi), 64'hFFFFFFFF);
    chk("ignore/lo", 64'(lo), 64'hFFFFFFE2);
    chk("ignore/s", 64'(s), 64'hFFFFFFE2);
    m_hi = 32'hFFFFFFFF; m_lo = 32'hFFFFFFE2; m_s = 32'hFFFFFFE2; m_z = 1'b0;
    @(posedge clk); #1;
    chk("ignore/done_low", 64'(done), 64'd0);

    // Reset aborts an in-flight divide
    op = 4'hB; a = 32'd100; b = 32'd3; st = 1'b1;
    @(posedge clk); #1;
    st = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    chk("abort/busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort/busy", 64'(busy), 64'd0);
    chk("abort/hi", 64'(hi), 64'd0);
    chk("abort/lo", 64'(lo), 64'd0);
    chk("abort/done", 64'(done), 64'd0);
    chk("abort/z", 64'(z), 64'd1);
    pulses = 0;
    repeat (40) begin @(posedge clk); #1; if (done) pulses++; end
    chk("abort/no_done", 64'(pulses), 64'd0);
    m_hi = '0; m_lo = '0; m_s = '0; m_z = 1'b1;

    // Randomized ops with corner-biased operands
    for (int i = 0; i < 150; i++) begin
      o = 4'($urandom_range(0, 15));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: x = 32'h80000000;
        2: y = 32'hFFFFFFFF;
        3: y = 32'($urandom_range(1, 9));
        4: x = 32'h7FFFFFFF;
        default: ;
      endcase
      apply(model(o, x, y), $sformatf("rnd%0d_op%0h", i, o));
    end

    // WIDTH=8: signed multiply of most-negative by itself
    op8 = 4'h8; a8 = 8'h80; b8 = 8'h80; st8 = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      st8 = 1'b0;
      n++;
    end while (!done8 && n < 100);
    chk("w8_mult/latency", 64'(n), 64'd10);
    chk("w8_mult/hi", 64'(hi8), 64'h40);
    chk("w8_mult/lo", 64'(lo8), 64'h00);
    chk("w8_mult/z", 64'(z8), 64'd1);
    @(posedge clk); #1;
    chk("w8_mult/done_low", 64'(done8), 64'd0);

    op8 = 4'h4; a8 = 8'h12; b8 = 8'h34; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    chk("w8_addu/s", 64'(s8), 64'h46);
    op8 = 4'hF; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    chk("w8_brk/done", 64'(done8), 64'd1);
    chk("w8_brk/brk", 64'(brk8), 64'd1);
    chk("w8_brk/s", 64'(s8), 64'h46);
    @(posedge clk); #1;
    chk("w8_brk/done_low", 64'(done8), 64'd0);
    chk("w8_brk/brk_low", 64'(brk8), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
